// File: rtl/winewhite_feature_loader_if.sv
// Stream bundle between the feature loader and its environment.
//   in_*  : feature beats into the loader (valid/ready, one FEAT_BITS nibble per beat,
//           in_last marks the final feature of a sample)
//   out_* : captured classifier result out of the loader (valid/ready, class + range error)
// Modports:
//   master : the environment (drives beats, consumes classes)
//   slave  : the loader (consumes beats, drives classes)
interface winewhite_feature_loader_if #(
  parameter int FEAT_BITS = 4,
  parameter int CW        = 3
);
  logic                 in_valid;
  logic                 in_ready;
  logic [FEAT_BITS-1:0] in_feat;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [CW-1:0]        out_class;
  logic                 out_err;

  modport master (
    output in_valid, in_feat, in_last, out_ready,
    input  in_ready, out_valid, out_class, out_err
  );

  modport slave (
    input  in_valid, in_feat, in_last, out_ready,
    output in_ready, out_valid, out_class, out_err
  );
endinterface

// File: rtl/winewhite_feature_loader.sv
// Feature loader for the combinational white-wine BNN classifier.
// Collects FEAT_CNT nibbles from a valid/ready stream into a registered, stable
// feature vector, lets the classifier settle for SETTLE_CYCLES cycles, captures
// its prediction and offers it downstream on a second valid/ready stream.
// Ports:
//   clk        : sole clock, rising edge
//   rst_n      : asynchronous active-low reset
//   bus        : stream bundle (slave side): in_valid/in_ready/in_feat/in_last,
//                out_valid/out_ready/out_class/out_err
//   features   : registered feature vector to the classifier, feature 0 in the MSB nibble
//   prediction : classifier output
//   frame_err  : one-cycle pulse after a beat that ends a malformed frame
module winewhite_feature_loader #(
  parameter int FEAT_CNT      = 11,
  parameter int FEAT_BITS     = 4,
  parameter int CLASS_CNT     = 7,
  parameter int SETTLE_CYCLES = 2,
  localparam int CW           = $clog2(CLASS_CNT)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  winewhite_feature_loader_if.slave     bus,
  output logic [FEAT_CNT*FEAT_BITS-1:0] features,
  input  logic [CW-1:0]                 prediction,
  output logic                          frame_err
);

  localparam int IDX_W = (FEAT_CNT > 1) ? $clog2(FEAT_CNT) : 1;
  localparam int SC_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(FEAT_CNT - 1);
  localparam logic [SC_W-1:0]  SETTLE_TOP = SC_W'(SETTLE_CYCLES - 1);
  // One extra bit so the range test also works when CLASS_CNT is a power of two.
  localparam logic [CW:0]      CLASS_LIM  = (CW + 1)'(CLASS_CNT);

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    DRAIN   = 2'd1,
    SETTLE  = 2'd2,
    PRESENT = 2'd3
  } state_e;

  state_e                        state_q,     state_d;
  logic [IDX_W-1:0]              idx_q,       idx_d;
  logic [SC_W-1:0]               settle_q,    settle_d;
  logic [FEAT_CNT*FEAT_BITS-1:0] features_q,  features_d;
  logic                          out_valid_q, out_valid_d;
  logic [CW-1:0]                 out_class_q, out_class_d;
  logic                          out_err_q,   out_err_d;
  logic                          frame_err_q, frame_err_d;

  logic in_ready;
  logic accept;

  assign in_ready = (state_q == LOAD) || (state_q == DRAIN);
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    settle_d    = settle_q;
    features_d  = features_q;
    out_valid_d = out_valid_q;
    out_class_d = out_class_q;
    out_err_d   = out_err_q;
    frame_err_d = 1'b0;

    unique case (state_q)
      LOAD: begin
        if (accept) begin
          // Feature 0 goes to the MSB nibble so the vector reads in memh text order.
          for (int i = 0; i < FEAT_CNT; i++) begin
            if (idx_q == IDX_W'(i)) begin
              features_d[(FEAT_CNT-1-i)*FEAT_BITS +: FEAT_BITS] = bus.in_feat;
            end
          end
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
            if (bus.in_last) begin
              state_d  = SETTLE;
              settle_d = SETTLE_TOP;
            end else begin
              // Frame too long: flag once, then swallow beats up to the next in_last.
              frame_err_d = 1'b1;
              state_d     = DRAIN;
            end
          end else if (bus.in_last) begin
            // Frame too short: restart; partial nibbles stay until overwritten.
            frame_err_d = 1'b1;
            idx_d       = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      DRAIN: begin
        if (accept && bus.in_last) begin
          state_d = LOAD;
        end
      end

      SETTLE: begin
        if (settle_q == '0) begin
          out_class_d = prediction;
          out_err_d   = ({1'b0, prediction} >= CLASS_LIM);
          out_valid_d = 1'b1;
          state_d     = PRESENT;
        end else begin
          settle_d = settle_q - SC_W'(1);
        end
      end

      PRESENT: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = LOAD;
        end
      end

      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      idx_q       <= '0;
      settle_q    <= '0;
      features_q  <= '0;
      out_valid_q <= 1'b0;
      out_class_q <= '0;
      out_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      settle_q    <= settle_d;
      features_q  <= features_d;
      out_valid_q <= out_valid_d;
      out_class_q <= out_class_d;
      out_err_q   <= out_err_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_class = out_class_q;
  assign bus.out_err   = out_err_q;
  assign features      = features_q;
  assign frame_err     = frame_err_q;

endmodule

// File: tb/tb_winewhite_feature_loader.sv
module tb_winewhite_feature_loader;

  localparam int FEAT_CNT  = 11;
  localparam int FEAT_BITS = 4;
  localparam int CLASS_CNT = 7;
  localparam int SETTLE    = 2;
  localparam int CW        = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [43:0]       features;
  logic [CW-1:0]     prediction;
  logic              frame_err;

  winewhite_feature_loader_if #(.FEAT_BITS(FEAT_BITS), .CW(CW)) bus ();

  winewhite_feature_loader #(
    .FEAT_CNT(FEAT_CNT), .FEAT_BITS(FEAT_BITS),
    .CLASS_CNT(CLASS_CNT), .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .features(features), .prediction(prediction), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (beat/sample level) ----------------
  logic [3:0] m_nib [FEAT_CNT];
  int         m_pos;
  bit         m_drain;
  int         m_settle;     // -1: no sample waiting on the classifier
  bit         m_hold;       // a class is being offered downstream
  logic [CW-1:0] m_class;
  bit         m_err;
  bit         m_ferr;

  function automatic logic [43:0] m_vec();
    logic [43:0] v;
    v = '0;
    for (int i = 0; i < FEAT_CNT; i++) v[(FEAT_CNT-1-i)*4 +: 4] = m_nib[i];
    return v;
  endfunction

  function automatic bit m_ready();
    return !(m_settle >= 0 || m_hold);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FEAT_CNT; i++) m_nib[i] = 4'h0;
      m_pos = 0; m_drain = 0; m_settle = -1; m_hold = 0;
      m_class = '0; m_err = 0; m_ferr = 0;
    end else begin
      m_ferr = 0;
      if (m_hold) begin
        if (bus.out_ready) m_hold = 0;
      end else if (m_settle >= 0) begin
        if (m_settle == 0) begin
          m_class  = prediction;
          m_err    = (int'(prediction) >= CLASS_CNT);
          m_hold   = 1;
          m_settle = -1;
        end else begin
          m_settle--;
        end
      end else if (bus.in_valid) begin
        if (m_drain) begin
          if (bus.in_last) m_drain = 0;
        end else begin
          m_nib[m_pos] = bus.in_feat;
          if (m_pos == FEAT_CNT-1) begin
            m_pos = 0;
            if (bus.in_last) m_settle = SETTLE - 1;
            else begin m_ferr = 1; m_drain = 1; end
          end else if (bus.in_last) begin
            m_ferr = 1; m_pos = 0;
          end else begin
            m_pos++;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("m_in_ready",  64'(bus.in_ready),  64'(m_ready()));
      check("m_out_valid", 64'(bus.out_valid), 64'(m_hold));
      check("m_features",  64'(features),      64'(m_vec()));
      check("m_frame_err", 64'(frame_err),     64'(m_ferr));
      if (m_hold) begin
        check("m_out_class", 64'(bus.out_class), 64'(m_class));
        check("m_out_err",   64'(bus.out_err),   64'(m_err));
      end
    end
  end

  // ---------------- monitors ----------------
  int cyc = 0;
  always @(posedge clk) cyc++;

  int ferr_cnt = 0;
  logic ov_prev = 1'b0;
  int rise_cyc[$];
  int rise_cls[$];
  int rise_err[$];
  always @(negedge clk) begin
    if (frame_err === 1'b1) ferr_cnt++;
    if (bus.out_valid === 1'b1 && ov_prev !== 1'b1) begin
      rise_cyc.push_back(cyc);
      rise_cls.push_back(int'(bus.out_class));
      rise_err.push_back(int'(bus.out_err));
    end
    ov_prev = bus.out_valid;
  end

  // ---------------- stimulus helpers ----------------
  // Called just after a rising edge; returns just after the edge that accepted the beat.
  task automatic send_beat(input logic [3:0] f, input logic l);
    bit acc;
    int n;
    bus.in_valid = 1'b1; bus.in_feat = f; bus.in_last = l;
    acc = 0; n = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      n_checks++; n_errors++;
      $display("FAIL beat_timeout: in_ready stayed %0b, expected 1 within 50 cycles", bus.in_ready);
    end
  endtask

  task automatic idle();
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_feat = '0;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (bus.out_valid !== 1'b1) begin
      n_checks++; n_errors++;
      $display("FAIL %s: out_valid=%0b, expected 1 within 40 cycles", name, bus.out_valid);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  int fe0;

  initial begin
    rst_n = 1'b0;
    prediction = '0;
    bus.out_ready = 1'b0;
    idle();

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_features",  64'(features),      64'h0);
    check("rst_out_valid", 64'(bus.out_valid), 64'h0);
    check("rst_out_class", 64'(bus.out_class), 64'h0);
    check("rst_out_err",   64'(bus.out_err),   64'h0);
    check("rst_frame_err", 64'(frame_err),     64'h0);
    check("rst_in_ready",  64'(bus.in_ready),  64'h1);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 64'(bus.in_ready), 64'h1);
    sync();

    // Clean frame 0..A, prediction 5, downstream stalled
    prediction = 3'd5;
    for (int i = 0; i < FEAT_CNT; i++) send_beat(4'(i), logic'(i == FEAT_CNT-1));
    idle();
    @(negedge clk); check("clean_ov_e0",   64'(bus.out_valid), 64'h0);
    @(negedge clk); check("clean_ov_e1",   64'(bus.out_valid), 64'h0);
    @(negedge clk); check("clean_ov_e2",   64'(bus.out_valid), 64'h1);
    check("clean_features", 64'(features),      64'h0123456789A);
    check("clean_class",    64'(bus.out_class), 64'h5);
    check("clean_err",      64'(bus.out_err),   64'h0);

    // Backpressure: six stalled cycles, prediction changes underneath
    for (int k = 0; k < 6; k++) begin
      if (k == 2) prediction = 3'd2;
      check("bp_out_valid", 64'(bus.out_valid), 64'h1);
      check("bp_class",     64'(bus.out_class), 64'h5);
      check("bp_features",  64'(features),      64'h0123456789A);
      check("bp_in_ready",  64'(bus.in_ready),  64'h0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("take_in_ready",  64'(bus.in_ready),  64'h1);
    check("take_out_valid", 64'(bus.out_valid), 64'h0);
    sync();

    // Early last on beat 4
    prediction = 3'd3;
    bus.out_ready = 1'b1;
    fe0 = ferr_cnt;
    for (int i = 0; i < 5; i++) send_beat(4'(9 - i), logic'(i == 4));
    idle();
    repeat (3) @(negedge clk);
    check("early_ferr_cnt",  64'(ferr_cnt - fe0), 64'h1);
    check("early_features",  64'(features),       64'h9876556789A);
    check("early_out_valid", 64'(bus.out_valid),  64'h0);
    sync();
    for (int i = 0; i < FEAT_CNT; i++) send_beat(4'hF, logic'(i == FEAT_CNT-1));
    idle();
    wait_valid("early_next_valid");
    check("early_next_features", 64'(features),      64'hFFFFFFFFFFF);
    check("early_next_class",    64'(bus.out_class), 64'h3);
    sync();

    // Missing last: 11 beats without last, 3 drained beats
    fe0 = ferr_cnt;
    for (int i = 0; i < FEAT_CNT; i++) send_beat(4'h5, 1'b0);
    for (int i = 0; i < 3; i++) send_beat(4'hC, logic'(i == 2));
    idle();
    repeat (2) @(negedge clk);
    check("miss_ferr_cnt",  64'(ferr_cnt - fe0), 64'h1);
    check("miss_features",  64'(features),       64'h55555555555);
    check("miss_out_valid", 64'(bus.out_valid),  64'h0);
    sync();
    prediction = 3'd6;
    for (int i = 0; i < FEAT_CNT; i++) send_beat(4'(10 - i), logic'(i == FEAT_CNT-1));
    idle();
    wait_valid("miss_next_valid");
    check("miss_next_features", 64'(features),      64'hA9876543210);
    check("miss_next_class",    64'(bus.out_class), 64'h6);
    check("miss_next_err",      64'(bus.out_err),   64'h0);
    repeat (2) sync();

    // Throughput with out-of-range prediction
    rise_cyc.delete(); rise_cls.delete(); rise_err.delete();
    prediction = 3'd7;
    bus.out_ready = 1'b1;
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < FEAT_CNT; i++) send_beat(4'(i + f), logic'(i == FEAT_CNT-1));
    idle();
    for (int n = 0; n < 40 && rise_cyc.size() < 3; n++) @(negedge clk);
    check("tp_rise_count", 64'(rise_cyc.size()), 64'd3);
    if (rise_cyc.size() >= 3) begin
      check("tp_period_1", 64'(rise_cyc[1] - rise_cyc[0]), 64'd14);
      check("tp_period_2", 64'(rise_cyc[2] - rise_cyc[1]), 64'd14);
      for (int k = 0; k < 3; k++) begin
        check("tp_class", 64'(rise_cls[k]), 64'd7);
        check("tp_err",   64'(rise_err[k]), 64'd1);
      end
    end
    repeat (2) sync();

    // Reset while a class is pending
    bus.out_ready = 1'b0;
    prediction = 3'd2;
    for (int i = 0; i < FEAT_CNT; i++) send_beat(4'h3, logic'(i == FEAT_CNT-1));
    idle();
    wait_valid("rst_mid_valid");
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", 64'(bus.out_valid), 64'h0);
    check("rst_mid_features",  64'(features),      64'h0);
    check("rst_mid_in_ready",  64'(bus.in_ready),  64'h1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_mid_after_valid", 64'(bus.out_valid), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
